// File: rtl/vm2002_change_dispenser.sv
// Change dispenser: pays out a cents amount greedily through the coin-tube eject solenoids.
// Optional dollar-coin tube enabled by defining VM2002_CHANGE_DOLLAR_EN.
module vm2002_change_dispenser #(
  parameter int unsigned PULSE_CYCLES = 4,
  parameter int unsigned GAP_CYCLES   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        change_req,
  input  logic [15:0] change_amt,
  input  logic [2:0]  tube_empty,
`ifdef VM2002_CHANGE_DOLLAR_EN
  input  logic        tube_empty_dol,
  output logic        eject_dol,
`endif
  output logic        eject_q,
  output logic        eject_d,
  output logic        eject_n,
  output logic        busy,
  output logic        done,
  output logic [15:0] shortfall,
  output logic        err
);

  localparam int unsigned AW = 16;
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_SELECT, S_EJECT, S_GAP, S_DONE} state_t;
  typedef enum logic [2:0] {COIN_NONE, COIN_Q, COIN_D, COIN_N, COIN_DOL} coin_t;

  state_t        state;
  logic [AW-1:0] rem;
  logic [CW-1:0] cnt;
  coin_t         pick;
  logic [AW-1:0] pick_val;

  // Greedy coin choice from the remaining amount and current tube sensors
  always_comb begin
    pick     = COIN_NONE;
    pick_val = '0;
`ifdef VM2002_CHANGE_DOLLAR_EN
    if (rem >= AW'(100) && !tube_empty_dol) begin
      pick     = COIN_DOL;
      pick_val = AW'(100);
    end else
`endif
    if (rem >= AW'(25) && !tube_empty[2]) begin
      pick     = COIN_Q;
      pick_val = AW'(25);
    end else if (rem >= AW'(10) && !tube_empty[1]) begin
      pick     = COIN_D;
      pick_val = AW'(10);
    end else if (rem >= AW'(5) && !tube_empty[0]) begin
      pick     = COIN_N;
      pick_val = AW'(5);
    end
  end

  // Sequencer; cnt is shared between the eject pulse and the inter-coin gap
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      rem       <= '0;
      cnt       <= '0;
      eject_q   <= 1'b0;
      eject_d   <= 1'b0;
      eject_n   <= 1'b0;
`ifdef VM2002_CHANGE_DOLLAR_EN
      eject_dol <= 1'b0;
`endif
      busy      <= 1'b0;
      done      <= 1'b0;
      shortfall <= '0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (change_req) begin
            rem       <= change_amt;
            shortfall <= '0;
            err       <= 1'b0;
            busy      <= 1'b1;
            state     <= S_SELECT;
          end
        end
        S_SELECT: begin
          if (pick == COIN_NONE) begin
            // shortfall is published together with the done pulse
            done      <= 1'b1;
            shortfall <= rem;
            err       <= (rem != '0);
            state     <= S_DONE;
          end else begin
            rem       <= rem - pick_val;
            eject_q   <= (pick == COIN_Q);
            eject_d   <= (pick == COIN_D);
            eject_n   <= (pick == COIN_N);
`ifdef VM2002_CHANGE_DOLLAR_EN
            eject_dol <= (pick == COIN_DOL);
`endif
            cnt       <= PULSE_LOAD;
            state     <= S_EJECT;
          end
        end
        S_EJECT: begin
          if (cnt == '0) begin
            eject_q   <= 1'b0;
            eject_d   <= 1'b0;
            eject_n   <= 1'b0;
`ifdef VM2002_CHANGE_DOLLAR_EN
            eject_dol <= 1'b0;
`endif
            cnt       <= GAP_LOAD;
            state     <= S_GAP;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_GAP: begin
          if (cnt == '0) begin
            state <= S_SELECT;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vm2002_change_dispenser.sv
// Bench for vm2002_change_dispenser: cycle-level expectation queue built from greedy payout
// arithmetic, plus literal per-test expectations pinned to cycle offsets from acceptance.
module tb_vm2002_change_dispenser;

  localparam int unsigned P = 4;
  localparam int unsigned G = 2;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic [2:0]  ej;    // {q, d, n}
    logic        last;
    logic [15:0] sf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        change_req = 1'b0;
  logic [15:0] change_amt = '0;
  logic [2:0]  tube_empty = '0;
  logic        eject_q, eject_d, eject_n, busy, done, err;
  logic [15:0] shortfall;
`ifdef VM2002_CHANGE_DOLLAR_EN
  logic        tube_empty_dol = 1'b1;
  logic        eject_dol;
`endif

  vm2002_change_dispenser #(.PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst(rst), .change_req(change_req), .change_amt(change_amt),
    .tube_empty(tube_empty),
`ifdef VM2002_CHANGE_DOLLAR_EN
    .tube_empty_dol(tube_empty_dol), .eject_dol(eject_dol),
`endif
    .eject_q(eject_q), .eject_d(eject_d), .eject_n(eject_n),
    .busy(busy), .done(done), .shortfall(shortfall), .err(err)
  );

  always #5 clk = ~clk;

  // Model state (written only by the posedge process)
  exp_t        mq[$];
  exp_t        cur = '0;
  logic [15:0] msf = '0;
  int          cyc = 0;
  int          acc_cyc = -1000;
  int          acc_tid = 0;
  int          tid = 0;

  // Checker state (written only by the negedge process)
  int n_tests = 0;
  int n_fail  = 0;
  int cnt_q = 0, cnt_d = 0, cnt_n = 0;
  int snap_q = 0, snap_d = 0, snap_n = 0;
  logic pq = 1'b0, pd = 1'b0, pn = 1'b0;
  int k;

  function automatic exp_t mk(logic b, logic d, logic [2:0] ej, logic last, logic [15:0] sf);
    exp_t e;
    e.busy = b; e.done = d; e.ej = ej; e.last = last; e.sf = sf;
    return e;
  endfunction

  // Expand a request into its full cycle-by-cycle expected output sequence
  task automatic build(input logic [15:0] amt, input logic [2:0] te);
    int unsigned r;
    int unsigned v;
    logic [2:0]  ej;
    r = amt;
    while (1) begin
      if (r >= 25 && !te[2]) begin ej = 3'b100; v = 25; end
      else if (r >= 10 && !te[1]) begin ej = 3'b010; v = 10; end
      else if (r >= 5 && !te[0]) begin ej = 3'b001; v = 5; end
      else break;
      mq.push_back(mk(1'b1, 1'b0, 3'b000, 1'b0, '0));
      repeat (P) mq.push_back(mk(1'b1, 1'b0, ej, 1'b0, '0));
      repeat (G) mq.push_back(mk(1'b1, 1'b0, 3'b000, 1'b0, '0));
      r = r - v;
    end
    mq.push_back(mk(1'b1, 1'b0, 3'b000, 1'b0, '0));
    mq.push_back(mk(1'b1, 1'b1, 3'b000, 1'b0, '0));
    mq.push_back(mk(1'b0, 1'b0, 3'b000, 1'b1, 16'(r)));
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      mq.delete();
      cur = '0;
      msf = '0;
    end else if (mq.size() != 0) begin
      cur = mq.pop_front();
      if (cur.last) msf = cur.sf;
    end else if (change_req) begin
      build(change_amt, tube_empty);
      cur = mq.pop_front();
      msf = '0;
      acc_cyc = cyc;
      acc_tid = tid;
    end
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] expv);
    n_tests = n_tests + 1;
    if (act !== expv) begin
      n_fail = n_fail + 1;
      $display("FAIL %s (test %0d, k=%0d): got %0d expected %0d", nm, acc_tid, k, act, expv);
    end
  endtask

  // Single compare process: model every cycle, then literal expectations by test and offset
  always @(negedge clk) begin
    k = cyc - acc_cyc + 1;
    if (k == 1) begin
      snap_q = cnt_q; snap_d = cnt_d; snap_n = cnt_n;
    end
    if (eject_q && !pq) cnt_q = cnt_q + 1;
    if (eject_d && !pd) cnt_d = cnt_d + 1;
    if (eject_n && !pn) cnt_n = cnt_n + 1;
    pq = eject_q; pd = eject_d; pn = eject_n;

    chk("busy", 16'(busy), 16'(cur.busy));
    chk("done", 16'(done), 16'(cur.done));
    chk("eject", 16'({eject_q, eject_d, eject_n}), 16'(cur.ej));
    if (!cur.done) begin
      chk("shortfall", shortfall, msf);
      chk("err", 16'(err), 16'(msf != '0));
    end
`ifdef VM2002_CHANGE_DOLLAR_EN
    chk("eject_dol", 16'(eject_dol), 16'd0);
`endif

    case (acc_tid)
      1: case (k)
           1:  chk("t1 busy k1", 16'(busy), 16'd1);
           2:  chk("t1 eject_q k2", 16'(eject_q), 16'd1);
           5:  chk("t1 eject_q k5", 16'(eject_q), 16'd1);
           6:  chk("t1 eject_q k6", 16'(eject_q), 16'd0);
           9:  chk("t1 eject_n k9", 16'(eject_n), 16'd1);
           12: chk("t1 eject_n k12", 16'(eject_n), 16'd1);
           16: chk("t1 done k16", 16'(done), 16'd1);
           17: begin
                 chk("t1 busy k17", 16'(busy), 16'd0);
                 chk("t1 shortfall", shortfall, 16'd0);
                 chk("t1 err", 16'(err), 16'd0);
               end
           default: ;
         endcase
      2: case (k)
           30: begin
                 chk("t2 done k30", 16'(done), 16'd1);
                 chk("t2 dime pulses", 16'(cnt_d - snap_d), 16'd4);
                 chk("t2 quarter pulses", 16'(cnt_q - snap_q), 16'd0);
               end
           31: chk("t2 shortfall", shortfall, 16'd0);
           default: ;
         endcase
      3: case (k)
           16: chk("t3 done k16", 16'(done), 16'd1);
           17: begin
                 chk("t3 shortfall", shortfall, 16'd2);
                 chk("t3 err", 16'(err), 16'd1);
                 chk("t3 q/d/n pulses", 16'((cnt_q - snap_q) * 100 + (cnt_d - snap_d) * 10 + (cnt_n - snap_n)), 16'd110);
               end
           default: ;
         endcase
      4: case (k)
           2: chk("t4 done k2", 16'(done), 16'd1);
           3: begin
                chk("t4 shortfall", shortfall, 16'd50);
                chk("t4 err", 16'(err), 16'd1);
              end
           default: ;
         endcase
      5: if (k == 10) chk("t5 quarter pulses", 16'(cnt_q - snap_q), 16'd1);
      6: if (k == 5) begin
           chk("t6 eject_q after rst", 16'(eject_q), 16'd0);
           chk("t6 busy after rst", 16'(busy), 16'd0);
           chk("t6 done after rst", 16'(done), 16'd0);
         end
      7: case (k)
           9:  chk("t7 done k9", 16'(done), 16'd1);
           10: chk("t7 nickel pulses", 16'(cnt_n - snap_n), 16'd1);
           default: ;
         endcase
      8: case (k)
           2: chk("t8 done k2", 16'(done), 16'd1);
           3: begin
                chk("t8 shortfall", shortfall, 16'd0);
                chk("t8 err", 16'(err), 16'd0);
                chk("t8 busy k3", 16'(busy), 16'd0);
              end
           default: ;
         endcase
      default: ;
    endcase
  end

  // Caller sits on a negedge; returns on the negedge of the SELECT cycle
  task automatic send(input int t, input logic [15:0] amt, input logic [2:0] te);
    tid = t;
    change_amt = amt;
    tube_empty = te;
    change_req = 1'b1;
    @(negedge clk);
    change_req = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(1, 16'd30, 3'b000);
    repeat (16) @(negedge clk);
    send(3, 16'd37, 3'b000);        // back-to-back, right after DONE
    repeat (18) @(negedge clk);
    send(2, 16'd40, 3'b100);
    repeat (31) @(negedge clk);
    send(4, 16'd50, 3'b111);
    repeat (3) @(negedge clk);
    send(8, 16'd0, 3'b000);
    repeat (3) @(negedge clk);
    send(5, 16'd25, 3'b000);
    repeat (2) @(negedge clk);
    change_amt = 16'd25;
    change_req = 1'b1;              // arrives during EJECT, must be dropped
    @(negedge clk);
    change_req = 1'b0;
    repeat (7) @(negedge clk);
    send(6, 16'd25, 3'b000);
    repeat (3) @(negedge clk);
    rst = 1'b1;                     // third EJECT cycle
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    send(7, 16'd5, 3'b000);
    repeat (12) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vm2002_change_dispenser.md
# vm2002_change_dispenser

Downstream stage of `vm2002`. It takes the refund or change amount the vending controller releases and drives the three coin-tube eject solenoids (quarter, dime, nickel) one coin at a time. It uses a greedy largest-coin-first algorithm and skips tubes whose empty sensor is set. When finished it reports any amount it could not pay out.

## Interface
Parameters:
- `PULSE_CYCLES`, default 4: cycles each eject solenoid line is held high; legal range 1–15.
- `GAP_CYCLES`, default 2: idle cycles between consecutive ejects; legal range 1–15.

Ports:
- `clk`  in  1: single clock; all logic on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `change_req`  in  1: one-cycle request; sampled only in IDLE.
- `change_amt`  in  16: amount in cents, captured with `change_req`.
- `tube_empty`  in  3: [2]=quarter, [1]=dime, [0]=nickel; 1 means the tube is empty.
- `eject_q`, `eject_d`, `eject_n`  out  1 each: solenoid drive; at most one high at any time.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse at completion.
- `shortfall`  out  16: cents not dispensed by the last request; held until the next accepted request.
- `err`  out  1: high when `shortfall` is nonzero; held with `shortfall`.

## Operation
- States are IDLE, SELECT, EJECT, GAP and DONE.
- **IDLE:**
  - On `change_req`=1, latch `change_amt` into 16-bit `rem`.
  - Clear `shortfall` and `err`.
  - Go to SELECT.
  - `change_req` outside IDLE is ignored with no queueing.
- **SELECT** (exactly 1 cycle): sample `tube_empty` this cycle and pick a coin by priority.
  1. If `rem`≥25 and the quarter tube is not empty, pick the quarter.
  2. Otherwise, if `rem`≥10 and the dime tube is not empty, pick the dime.
  3. Otherwise, if `rem`≥5 and the nickel tube is not empty, pick the nickel.
  4. Otherwise go to DONE.
  - When a coin is picked, subtract its value from `rem` at the same edge and go to EJECT.
- **EJECT:** hold the selected `eject_*` high for `PULSE_CYCLES` cycles, then go to GAP.
- **GAP:** all `eject_*` low for `GAP_CYCLES` cycles, then go to SELECT.
- **DONE** (1 cycle):
  - `done`=1.
  - `shortfall`←`rem`; `err`←(`rem`≠0).
  - Next state is IDLE.
- Arithmetic:
  - `rem` is unsigned 16-bit.
  - Subtraction never underflows, because a coin is picked only when `rem` ≥ its value.
  - A residue of `change_amt` mod 5 always ends up in `shortfall`.
- A tube that empties mid-request is honoured at the next SELECT. The dispenser then falls back to smaller coins.
- One 4-bit down-counter is shared by EJECT and GAP.

## Timing
- Reset values:
  - State is IDLE.
  - `eject_q`/`eject_d`/`eject_n`=0, `busy`=0, `done`=0.
  - `shortfall`=0, `err`=0, `rem`=0.
- Reset mid-operation: all outputs take their reset values at the next rising edge. The in-flight request is discarded and no `done` pulse is produced.
- Request accepted at edge *t*: SELECT occupies cycle *t*+1 and `busy`=1 from *t*+1.
- First eject runs from cycle *t*+2 to *t*+1+`PULSE_CYCLES`.
- Per coin: 1 + `PULSE_CYCLES` + `GAP_CYCLES` cycles.
- Completion: the final SELECT is followed by 1 DONE cycle, then IDLE.
- `busy` falls in the same cycle that IDLE is re-entered, one cycle after the `done` pulse.
- `change_amt`=0: SELECT, then DONE, with `done` at cycle *t*+2, `shortfall`=0 and `err`=0.
- `change_req` in the IDLE cycle directly after DONE is accepted; no dead cycle is required.

## Configuration
- Macro `VM2002_CHANGE_DOLLAR_EN`.
- **Defined:**
  - Adds input `tube_empty_dol` (1 bit) and output `eject_dol` (1 bit, reset 0).
  - SELECT checks `rem`≥100 with the dollar tube not empty first, ahead of the quarter.
- **Undefined:**
  - Neither port exists.
  - Greedy order starts at the quarter; all other behaviour is identical.

## Test plan
- Reset, then `change_amt`=30, all tubes full, defaults → `eject_q` high cycles 2–5, `eject_n` high cycles 9–12, `done` at cycle 16, `shortfall`=0, `err`=0, `busy` low at cycle 17.
- `change_amt`=40 with `tube_empty`=3'b100 → four dimes, never `eject_q`; `done` with `shortfall`=0.
- `change_amt`=37 with all tubes full → quarter, dime, then `done` with `shortfall`=2 and `err`=1.
- `change_amt`=50, `tube_empty`=3'b111 → no eject, `done` at cycle 2, `shortfall`=50, `err`=1.
- `change_req` with amount 25 asserted during EJECT of a prior 25-cent request → ignored; exactly one `eject_q` pulse in total.
- `rst` raised in the third cycle of an EJECT → `eject_q`=0 and `busy`=0 at the next edge, no `done`; a fresh request of 5 afterwards gives one `eject_n` pulse.
